// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices 0..LAST_IDX through a read port and streams each word out with a ready/valid handshake.
module reg_dump_reader #(
  parameter int DATA_W   = 64,
  parameter int LAST_IDX = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [4:0]        RA,
  input  logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] DumpData,
  output logic [4:0]        DumpIdx,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum
);
  typedef enum logic [1:0] {IDLE, ADDR, SEND, FIN} state_t;
  state_t state, nextState;
  logic [4:0] idx;
  logic handshake, lastIdx;
  assign handshake = state == SEND && DumpValid && DumpReady;
  assign lastIdx = idx == 5'(LAST_IDX);
  always_ff @(posedge Clk) state <= Reset ? IDLE : nextState;
  always_comb begin
    nextState = state == IDLE ? (Start ? ADDR : IDLE) :
                state == ADDR ? SEND :
                state == SEND ? (handshake ? (lastIdx ? FIN : ADDR) : SEND) : IDLE;
  end
  // index stops at LAST_IDX so RA keeps pointing at the final register through FIN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx <= '0;
      DumpData <= '0;
      DumpIdx <= '0;
      DumpValid <= 1'b0;
      Checksum <= '0;
    end else begin
      if (state == IDLE && Start) begin
        idx <= '0;
        Checksum <= '0;
      end
      if (state == ADDR) begin
        DumpData <= BusA;
        DumpIdx <= idx;
        DumpValid <= 1'b1;
      end
      if (handshake) begin
        Checksum <= Checksum ^ DumpData;
        DumpValid <= 1'b0;
        if (!lastIdx) idx <= idx + 5'd1;
      end
    end
  end
  always_comb begin
    RA = idx;
    Busy = state != IDLE;
    Done = state == FIN;
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: table vectors for reset/start/handshake corners plus whole-dump runs checked against an array register model.
module tb_reg_dump_reader;
  localparam logic [63:0] R1 = 64'h0101010101010101;
  logic Clk = 1'b0, Reset, Start, DumpReady, DumpValid, Busy, Done;
  logic [4:0] RA, DumpIdx;
  logic [63:0] BusA, DumpData, Checksum;
  logic [63:0] regs [32];
  int compared = 0, mismatched = 0;

  reg_dump_reader #(.DATA_W(64), .LAST_IDX(31)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RA(RA), .BusA(BusA),
    .DumpData(DumpData), .DumpIdx(DumpIdx), .DumpValid(DumpValid),
    .DumpReady(DumpReady), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  always #5 Clk = ~Clk;
  assign BusA = regs[RA];

  typedef struct {
    logic rst, st, rdy, busy, vld, done;
    logic [4:0] ra, idx;
    logic [63:0] data, ck;
  } vec_t;
  vec_t vecs [11];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [63:0] ck);
    check({tag, ".Busy"}, 64'(Busy), 64'd0);
    check({tag, ".DumpValid"}, 64'(DumpValid), 64'd0);
    check({tag, ".Done"}, 64'(Done), 64'd0);
    check({tag, ".Checksum"}, Checksum, ck);
  endtask

  // one full dump; stallAt holds Ready low 5 valid cycles at that index, abortAt resets mid-SEND,
  // noise pulses Start at index 12 and in FIN
  task automatic runDump(input int readyPct, input int stallAt, input int abortAt, input bit noise,
                         output logic [63:0] ck);
    int expIdx, cyc, stall;
    logic [63:0] expCk;
    bit hs, vld;
    expIdx = 0; expCk = '0; stall = 0; cyc = 0; ck = '0;
    Start = 1'b1;
    DumpReady = 1'b1;
    step();
    Start = 1'b0;
    check("acc.Busy", 64'(Busy), 64'd1);
    check("acc.RA", 64'(RA), 64'd0);
    check("acc.Checksum", Checksum, 64'd0);
    check("acc.DumpValid", 64'(DumpValid), 64'd0);
    while (!Done && cyc < 4000) begin
      vld = DumpValid;
      if (vld && expIdx < 32) begin
        check("DumpIdx", 64'(DumpIdx), 64'(expIdx));
        check("DumpData", DumpData, regs[expIdx]);
      end
      check("RA", 64'(RA), 64'(expIdx > 31 ? 31 : expIdx));
      if (vld && expIdx == abortAt) begin
        Reset = 1'b1;
        DumpReady = 1'b1;
        Start = 1'b1;
        step();
        Reset = 1'b0;
        Start = 1'b0;
        checkIdle("abort", 64'd0);
        check("abort.RA", 64'(RA), 64'd0);
        check("abort.DumpIdx", 64'(DumpIdx), 64'd0);
        check("abort.DumpData", DumpData, 64'd0);
        return;
      end
      if (vld && expIdx == stallAt && stall < 5) begin
        DumpReady = 1'b0;
        stall++;
      end else DumpReady = $urandom_range(99) < readyPct;
      Start = noise && expIdx == 12;
      hs = vld && DumpReady;
      step();
      cyc++;
      if (hs) begin
        expCk ^= regs[expIdx];
        expIdx++;
        check("hs.DumpValid", 64'(DumpValid), 64'd0);
        check("hs.Checksum", Checksum, expCk);
      end
    end
    check("Done", 64'(Done), 64'd1);
    check("words", 64'(expIdx), 64'd32);
    check("fin.RA", 64'(RA), 64'd31);
    if (readyPct == 100 && stallAt < 0) check("latency", 64'(cyc), 64'd64);
    ck = Checksum;
    Start = noise;
    step();
    Start = 1'b0;
    checkIdle("postFin", expCk);
  endtask

  initial begin
    logic [63:0] ck;
    Reset = 1'b1; Start = 1'b0; DumpReady = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = i == 31 ? 64'd0 : 64'(i) * R1;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 64'd0, 64'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, R1, 64'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0};
    for (int v = 0; v < 11; v++) begin
      Reset = vecs[v].rst; Start = vecs[v].st; DumpReady = vecs[v].rdy;
      step();
      check($sformatf("vec%0d.Busy", v), 64'(Busy), 64'(vecs[v].busy));
      check($sformatf("vec%0d.DumpValid", v), 64'(DumpValid), 64'(vecs[v].vld));
      check($sformatf("vec%0d.Done", v), 64'(Done), 64'(vecs[v].done));
      check($sformatf("vec%0d.RA", v), 64'(RA), 64'(vecs[v].ra));
      check($sformatf("vec%0d.DumpIdx", v), 64'(DumpIdx), 64'(vecs[v].idx));
      check($sformatf("vec%0d.DumpData", v), DumpData, vecs[v].data);
      check($sformatf("vec%0d.Checksum", v), Checksum, vecs[v].ck);
    end
    Reset = 1'b0; Start = 1'b0;
    runDump(100, -1, -1, 1'b0, ck);
    check("ramp.Checksum", ck, 64'h1F1F1F1F1F1F1F1F);
    runDump(100, -1, -1, 1'b0, ck);
    check("b2b.Checksum", ck, 64'h1F1F1F1F1F1F1F1F);
    runDump(100, 7, -1, 1'b0, ck);
    runDump(100, -1, -1, 1'b1, ck);
    runDump(100, -1, 20, 1'b0, ck);
    runDump(100, -1, -1, 1'b0, ck);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
      runDump(60, -1, -1, 1'b0, ck);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have these parameters:
  DATA_W, 64, register word width.
  LAST_IDX, 31, highest register index dumped (dump covers 0..LAST_IDX).
REQ-002 The block SHALL have these ports, one clock, synchronous active-high reset:
  Clk       input   1       clock; all state updates on rising edge
  Reset     input   1       synchronous active-high reset
  Start     input   1       request a full register dump; sampled only in IDLE
  RA        output  5       read-port address driven to the register file
  BusA      input   DATA_W  read-port data returned by the register file (combinational, settles within one cycle)
  DumpData  output  DATA_W  captured register value
  DumpIdx   output  5       register index of DumpData
  DumpValid output  1       DumpData/DumpIdx valid
  DumpReady input   1       consumer accepts the current word
  Busy      output  1       high in any state other than IDLE
  Done      output  1       one-cycle pulse after final word accepted
  Checksum  output  DATA_W  XOR of all words accepted in the current/last dump

Function
REQ-003 The block SHALL implement states IDLE, ADDR, SEND, FIN.
REQ-004 IDLE: Start=1 SHALL clear index counter to 0, clear Checksum to 0, go to ADDR; Start=0 SHALL hold IDLE.
REQ-005 RA SHALL equal the index counter in every state.
REQ-006 ADDR: lasts exactly one cycle; at its closing edge BusA SHALL be captured into DumpData, index into DumpIdx, DumpValid set to 1, state to SEND.
REQ-007 SEND: DumpValid SHALL remain 1 and DumpData/DumpIdx SHALL remain stable until a handshake (DumpValid=1 and DumpReady=1 at a rising edge).
REQ-008 On handshake, Checksum SHALL become Checksum XOR DumpData and DumpValid SHALL clear to 0 at that edge.
REQ-009 On handshake with index < LAST_IDX, index SHALL increment by 1 and state go to ADDR.
REQ-010 On handshake with index = LAST_IDX, state SHALL go to FIN; index SHALL not wrap.
REQ-011 FIN: Done SHALL be 1 for exactly this one cycle, then state returns to IDLE.
REQ-012 Start SHALL be ignored in ADDR, SEND and FIN; no restart or queueing.
REQ-013 Start=1 in the IDLE cycle immediately following FIN SHALL begin a new dump.
REQ-014 Checksum SHALL hold its final value in IDLE until the next Start is accepted.
REQ-015 Register 31 SHALL be read like any other index; the block applies no zero substitution (value is whatever BusA returns).
REQ-016 With DumpReady held 1, per-word latency SHALL be 2 cycles and a full dump SHALL take 2*(LAST_IDX+1) cycles from Start acceptance to FIN entry.
REQ-017 The block SHALL never issue register writes and SHALL have no write-side ports.
REQ-018 DumpReady while DumpValid=0 SHALL have no effect.

Reset
REQ-019 Reset=1 at a rising edge SHALL force IDLE from any state, including mid-dump.
REQ-020 After reset: RA=0, DumpData=0, DumpIdx=0, DumpValid=0, Busy=0, Done=0, Checksum=0.
REQ-021 Reset SHALL take priority over Start and handshake in the same cycle.

Verification
REQ-022 Register file model with reg[i]=i*0x0101010101010101 (reg31 returns 0), DumpReady=1, pulse Start -> 32 words, DumpIdx 0..31 in order, DumpData matching, Done pulse 64 cycles after Start acceptance, Checksum = XOR of reg[0..30].
REQ-023 DumpReady held 0 for 5 cycles at index 7 -> DumpValid stays 1, DumpIdx=7 and DumpData stable all 5 cycles; index 8 follows only after Ready rises.
REQ-024 Start pulsed again at index 12 and in FIN -> ignored; single dump of 32 words, single Done pulse.
REQ-025 Reset asserted while in SEND at index 20 -> next cycle all outputs at reset values, Busy=0; subsequent Start dumps from index 0 with Checksum restarting at 0.
REQ-026 Reset and Start both 1 in IDLE -> remains IDLE, Busy=0; Start alone next cycle -> Busy=1, RA=0.
REQ-027 Back-to-back dumps (Start high in cycle after Done) -> second dump begins immediately, Checksum of second dump equals first for identical register contents.
